// File: rtl/dram_burst_ctrl.sv
// Burst front-end: splits a byte-addressed client burst into 8-lane DRAM beats,
// paces write turnaround and read latency, and returns read beats under valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request, req_ready high
// ISSUE   | drive one beat onto the DRAM lanes (write waits for wr_valid)
// WAIT_RD | read issued, waiting for dram_valid or timeout
// WAIT_WR | write issued, waiting out DRAM turnaround
// RESP    | read beat presented to client until accepted
// DONE    | one-cycle done (and err on timeout) pulse
module dram_burst_ctrl #(
   parameter int WR_TURNAROUND = 22,
   parameter int RD_TIMEOUT    = 64,
   parameter int LEN_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_rdwr,
   input  logic [63:0]      req_addr,
   input  logic [LEN_W-1:0] req_len,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [63:0]      wr_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_data,
   output logic [7:0]       rsp_keep,
   output logic             rsp_last,
   output logic             done,
   output logic             err,
   output logic [7:0]       dram_en,
   output logic             dram_rdwr,
   output logic [63:0]      dram_data_in,
   output logic [511:0]     dram_addr,
   input  logic [63:0]      dram_data_out,
   input  logic [7:0]       dram_valid
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE   = 3'd1;
   localparam logic [2:0] S_WAIT_RD = 3'd2;
   localparam logic [2:0] S_WAIT_WR = 3'd3;
   localparam logic [2:0] S_RESP    = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam int TMR_MAX = (WR_TURNAROUND > RD_TIMEOUT) ? WR_TURNAROUND : RD_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   // Timers are loaded in the issue cycle and expire at zero, so load N-2.
   localparam logic [TMR_W-1:0] WR_LOAD = TMR_W'(WR_TURNAROUND - 2);
   localparam logic [TMR_W-1:0] RD_LOAD = TMR_W'(RD_TIMEOUT - 2);

   logic [2:0]       state;
   logic             live_q;
   logic             rdwr_q;
   logic             err_q;
   logic [63:0]      beat_addr;
   logic [LEN_W-1:0] remaining;
   logic [TMR_W-1:0] timer;
   logic             rdwr_hold;
   logic [63:0]      data_hold;
   logic [511:0]     addr_hold;

   logic [7:0]       mask;
   logic [511:0]     lane_addr;
   logic [LEN_W-1:0] beat_n;
   logic             last_beat;
   logic             issue;

   always_comb begin
      mask      = '0;
      lane_addr = '0;
      for (int i = 0; i < 8; i++) begin
         mask[i] = remaining > LEN_W'(i);
         lane_addr[64*i +: 64] = mask[i] ? beat_addr + 64'(i) : 64'h0;
      end
      last_beat = remaining <= LEN_W'(8);
      beat_n    = last_beat ? remaining : LEN_W'(8);
   end

   assign issue        = (state == S_ISSUE) && (rdwr_q || wr_valid);
   assign req_ready    = (state == S_IDLE) && live_q;
   assign wr_ready     = (state == S_ISSUE) && !rdwr_q;
   assign rsp_valid    = (state == S_RESP);
   assign rsp_last     = (state == S_RESP) && last_beat;
   assign done         = (state == S_DONE);
   assign err          = (state == S_DONE) && err_q;
   assign dram_en      = issue ? mask : 8'h0;
   assign dram_rdwr    = issue ? rdwr_q : rdwr_hold;
   assign dram_addr    = issue ? lane_addr : addr_hold;
   assign dram_data_in = (issue && !rdwr_q) ? wr_data : data_hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         live_q    <= 1'b0;
         rdwr_q    <= 1'b0;
         err_q     <= 1'b0;
         beat_addr <= '0;
         remaining <= '0;
         timer     <= '0;
         rdwr_hold <= 1'b0;
         data_hold <= '0;
         addr_hold <= '0;
         rsp_data  <= '0;
         rsp_keep  <= '0;
      end else begin
         live_q <= 1'b1;
         case (state)
            S_IDLE: begin
               if (req_valid && live_q) begin
                  rdwr_q    <= req_rdwr;
                  beat_addr <= req_addr;
                  remaining <= req_len;
                  err_q     <= 1'b0;
                  state     <= (req_len == '0) ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (issue) begin
                  rdwr_hold <= rdwr_q;
                  addr_hold <= lane_addr;
                  if (!rdwr_q) data_hold <= wr_data;
                  timer <= rdwr_q ? RD_LOAD : WR_LOAD;
                  state <= rdwr_q ? S_WAIT_RD : S_WAIT_WR;
               end
            end
            S_WAIT_RD: begin
               if (dram_valid != 8'h0) begin
                  rsp_data <= dram_data_out;
                  rsp_keep <= mask;
                  state    <= S_RESP;
               end else if (timer == '0) begin
                  err_q <= 1'b1;
                  state <= S_DONE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_WAIT_WR: begin
               if (timer == '0) begin
                  beat_addr <= beat_addr + 64'd8;
                  remaining <= remaining - beat_n;
                  state     <= last_beat ? S_DONE : S_ISSUE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  beat_addr <= beat_addr + 64'd8;
                  remaining <= remaining - beat_n;
                  state     <= last_beat ? S_DONE : S_ISSUE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
